dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Shares the single synchronous-read data RAM between the MEM stage and a debug/display access port. It arbitrates per cycle, drives the RAM address, write enable and write data, and routes the read data back to the owner one cycle later. The MEM stage has priority. A starvation counter guarantees the debug port a slot under sustained MEM traffic. It sits between mem and the data RAM at the top level.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the debug port may lose to MEM before it is forced a grant (legal range 1..15)
PROT_BASE, 32'h0000_0000, lowest debug-writable byte address (used only with the optional feature)
PROT_TOP, 32'h0000_0FFF, highest debug-writable byte address (used only with the optional feature)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_req  in  1  MEM stage access request, held until granted
mem_addr  in  32  MEM byte address
mem_wen  in  4  MEM byte write enables; 0 means read
mem_wdata  in  32  MEM write data, already lane-aligned
mem_gnt  out  1  MEM access accepted this cycle (combinational)
mem_rvalid  out  1  MEM response; pulses the cycle after a MEM grant
mem_rdata  out  32  RAM read data for MEM; valid when mem_rvalid
dbg_req  in  1  debug request, held until granted
dbg_addr  in  32  debug byte address
dbg_wen  in  4  debug byte write enables
dbg_wdata  in  32  debug write data
dbg_gnt  out  1  debug access accepted this cycle (combinational)
dbg_rvalid  out  1  debug response; pulses the cycle after a debug grant
dbg_rdata  out  32  RAM read data for debug
dm_addr  out  32  RAM address
dm_wen  out  4  RAM byte write enables
dm_wdata  out  32  RAM write data
dm_rdata  in  32  RAM read data, available one cycle after the address is presented
dbg_werr  out  1  sticky protection violation flag (0 unless the optional feature is enabled)

Behaviour:
- Reset (asynchronous, resetn=0):
  - mem_rvalid=0, dbg_rvalid=0, dbg_werr=0.
  - Starvation counter starve_cnt=0; owner register resp_owner=NONE.
  - Combinational outputs follow the grant equations; with no request they are dm_wen=0, dm_addr=0, dm_wdata=0.
- Grant decision (combinational, one winner per cycle):
  - force_dbg = dbg_req && starve_cnt >= STARVE_LIMIT.
  - dbg_gnt = dbg_req && (!mem_req || force_dbg).
  - mem_gnt = mem_req && !dbg_gnt.
- RAM drive: mux selected by the grant.
  - When neither port is granted, dm_wen=0 and dm_addr/dm_wdata hold 0.
  - A non-granted port's wen never reaches the RAM.
- Response pipeline, registered:
  - resp_owner <= MEM / DBG / NONE per this cycle's grant.
  - Next cycle: rvalid pulses for that owner for reads and writes alike.
  - rdata for both ports is dm_rdata, but only the owner's rvalid asserts.
  - Latency is exactly 1 cycle from grant to rvalid.
  - Back-to-back grants give back-to-back rvalids, with no bubble.
- Starvation counter:
  - Increments (saturating at 15) each cycle dbg_req=1 && mem_gnt=1.
  - Clears to 0 on any dbg_gnt.
  - Also clears on any cycle with dbg_req=0.
- Boundary cases:
  - Both ports request with starve_cnt<STARVE_LIMIT: MEM wins.
  - Forced cycle: MEM is stalled exactly one cycle (mem_gnt=0); MEM holds its request and wins the next cycle.
  - Request dropped before grant: no effect on the RAM, no rvalid.
  - Reset mid-access: the pending rvalid is lost; the requester must reissue.
- Protocol assumption (checked by assertion, not enforced): a requester does not change addr/wen/wdata while req=1 and not yet granted.

Optional Feature:
Macro: DM_ARB_DBG_WPROT_EN.
- Defined:
  - A debug grant with dbg_wen!=0 and dbg_addr outside [PROT_BASE, PROT_TOP] is still granted and still returns dbg_rvalid.
  - dm_wen is forced to 0 for that access.
  - dbg_werr is set the following cycle and stays 1 until reset.
  - Debug reads are never blocked; MEM accesses are never checked.
- Not defined: no check is made, all debug writes pass through, and dbg_werr is tied to 0.

Test Plan:
1. mem_req=1, addr=0x10, wen=0 for one cycle, RAM holds 0xDEADBEEF at 0x10 -> same cycle mem_gnt=1 and dm_addr=0x10; next cycle mem_rvalid=1 with mem_rdata=0xDEADBEEF and dbg_rvalid=0.
2. mem_req and dbg_req both held high for 12 cycles, STARVE_LIMIT=4 -> grant pattern MMMMDMMMMDMM; starve_cnt returns to 0 after each D slot.
3. dbg write addr=0x20, wen=4'b0011, wdata=0x1234ABCD with mem_req=0, then dbg read of 0x20 -> dm_wen=0011 on the write cycle; readback lower half=0xABCD, dbg_rvalid pulses once per access.
4. MEM write of 0x55 to 0x40 in cycle N, MEM read of 0x40 in cycle N+1 -> mem_rvalid high in N+1 and N+2; N+2 data shows 0x55 in the written lane; no bubble between the two.
5. resetn deasserted low for 1 cycle right after a mem grant -> mem_rvalid stays 0, starve_cnt=0, and a fresh request afterwards is granted normally.
6. With DM_ARB_DBG_WPROT_EN defined, PROT_TOP=0xFFF, dbg write to 0x2000 -> dm_wen=0, dbg_rvalid=1, dbg_werr=1 from the next cycle on; a following write to 0x100 is written and dbg_werr remains 1.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles every bus-level signal of the data-RAM arbiter.
//   MEM port : mem_req/addr/wen/wdata  -> mem_gnt/rvalid/rdata
//   DBG port : dbg_req/addr/wen/wdata  -> dbg_gnt/rvalid/rdata, dbg_werr
//   RAM side : dm_addr/wen/wdata       <- dm_rdata
// Modports:
//   slave  : the arbiter's view (consumes requests, drives grants and the RAM)
//   master : the surrounding system's view (requesters plus the RAM model)
// -----------------------------------------------------------------------------
interface dm_arbiter_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic [3:0]  dbg_wen;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        dbg_werr;

   logic [31:0] dm_addr;
   logic [3:0]  dm_wen;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   modport slave (
      input  mem_req, mem_addr, mem_wen, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  dbg_req, dbg_addr, dbg_wen, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_werr,
      output dm_addr, dm_wen, dm_wdata,
      input  dm_rdata
   );

   modport master (
      output mem_req, mem_addr, mem_wen, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output dbg_req, dbg_addr, dbg_wen, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_werr,
      input  dm_addr, dm_wen, dm_wdata,
      output dm_rdata
   );
endinterface

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares one synchronous-read data RAM between the MEM stage (priority) and a
// debug/display port. One grant per cycle; the read data comes back one cycle
// after the grant, flagged by the owner's rvalid. A starvation counter forces
// a debug slot after STARVE_LIMIT consecutive losses to MEM.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : dm_arbiter_if.slave (MEM port, DBG port, RAM side)
// Optional feature macro: DM_ARB_DBG_WPROT_EN
//   When defined, debug writes outside [PROT_BASE, PROT_TOP] are granted but
//   suppressed at the RAM, and the sticky dbg_werr flag is raised.
//   When undefined, dbg_werr is tied low and all debug writes pass.
// Also contains dm_arbiter_chk, a per-port protocol checker.
// -----------------------------------------------------------------------------
module dm_arbiter #(
`ifdef DM_ARB_DBG_WPROT_EN
   parameter logic [31:0] PROT_BASE    = 32'h0000_0000,
   parameter logic [31:0] PROT_TOP     = 32'h0000_0FFF,
`endif
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          resetn,
   dm_arbiter_if.slave   bus
);

   // One-hot-style encoding so each rvalid is a direct register bit.
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_MEM  = 2'b01,
      OWN_DBG  = 2'b10
   } owner_e;

   owner_e      resp_owner_q, resp_owner_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        force_dbg_s;
   logic        dbg_gnt_s;
   logic        mem_gnt_s;
   logic [3:0]  dbg_wen_eff_s;
   logic [31:0] dm_addr_s;
   logic [3:0]  dm_wen_s;
   logic [31:0] dm_wdata_s;

   assign force_dbg_s = bus.dbg_req && (starve_cnt_q >= 4'(STARVE_LIMIT));
   assign dbg_gnt_s   = bus.dbg_req && (!bus.mem_req || force_dbg_s);
   assign mem_gnt_s   = bus.mem_req && !dbg_gnt_s;

`ifdef DM_ARB_DBG_WPROT_EN
   logic werr_q, werr_d;
   logic wprot_viol_s;

   // Flag a granted debug write whose address falls outside the window.
   always_comb begin
      wprot_viol_s = 1'b0;
      if (dbg_gnt_s && (|bus.dbg_wen) &&
          ((bus.dbg_addr < PROT_BASE) || (bus.dbg_addr > PROT_TOP))) begin
         wprot_viol_s = 1'b1;
      end else begin
         wprot_viol_s = 1'b0;
      end
   end

   assign dbg_wen_eff_s = wprot_viol_s ? 4'b0000 : bus.dbg_wen;
   assign werr_d        = werr_q | wprot_viol_s;
   assign bus.dbg_werr  = werr_q;
`else
   assign dbg_wen_eff_s = bus.dbg_wen;
   assign bus.dbg_werr  = 1'b0;
`endif

   // RAM drive mux: only the winner reaches the RAM, idle drives zeros.
   always_comb begin
      dm_addr_s  = 32'h0000_0000;
      dm_wen_s   = 4'b0000;
      dm_wdata_s = 32'h0000_0000;
      if (dbg_gnt_s) begin
         dm_addr_s  = bus.dbg_addr;
         dm_wen_s   = dbg_wen_eff_s;
         dm_wdata_s = bus.dbg_wdata;
      end else if (mem_gnt_s) begin
         dm_addr_s  = bus.mem_addr;
         dm_wen_s   = bus.mem_wen;
         dm_wdata_s = bus.mem_wdata;
      end else begin
         dm_addr_s  = 32'h0000_0000;
         dm_wen_s   = 4'b0000;
         dm_wdata_s = 32'h0000_0000;
      end
   end

   // Next-state for response owner and starvation counter.
   always_comb begin
      resp_owner_d = OWN_NONE;
      starve_cnt_d = starve_cnt_q;
      if (dbg_gnt_s) begin
         resp_owner_d = OWN_DBG;
      end else if (mem_gnt_s) begin
         resp_owner_d = OWN_MEM;
      end else begin
         resp_owner_d = OWN_NONE;
      end
      // dbg_req with no dbg grant implies MEM won, so only count that case.
      if (!bus.dbg_req || dbg_gnt_s) begin
         starve_cnt_d = 4'd0;
      end else if (mem_gnt_s && (starve_cnt_q != 4'd15)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_owner_q <= OWN_NONE;
         starve_cnt_q <= 4'd0;
`ifdef DM_ARB_DBG_WPROT_EN
         werr_q       <= 1'b0;
`endif
      end else begin
         resp_owner_q <= resp_owner_d;
         starve_cnt_q <= starve_cnt_d;
`ifdef DM_ARB_DBG_WPROT_EN
         werr_q       <= werr_d;
`endif
      end
   end

   assign bus.mem_gnt    = mem_gnt_s;
   assign bus.dbg_gnt    = dbg_gnt_s;
   assign bus.mem_rvalid = resp_owner_q[0];
   assign bus.dbg_rvalid = resp_owner_q[1];
   assign bus.mem_rdata  = bus.dm_rdata;
   assign bus.dbg_rdata  = bus.dm_rdata;
   assign bus.dm_addr    = dm_addr_s;
   assign bus.dm_wen     = dm_wen_s;
   assign bus.dm_wdata   = dm_wdata_s;

endmodule

// -----------------------------------------------------------------------------
// dm_arbiter_chk
// Protocol checker for one requester: while a request is pending and not yet
// granted, its payload must stay stable (dropping the request is allowed).
// -----------------------------------------------------------------------------
module dm_arbiter_chk (
   input logic        clk_i,
   input logic        rst_n_i,
   input logic        req_i,
   input logic        gnt_i,
   input logic [31:0] addr_i,
   input logic [3:0]  wen_i,
   input logic [31:0] wdata_i
);
   a_payload_stable : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (req_i && !gnt_i) |=> (!req_i ||
         ($stable(addr_i) && $stable(wen_i) && $stable(wdata_i))))
      else $error("dm_arbiter_chk: request payload changed while pending");
endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a small synchronous-read RAM model.
// Covers reset state, single MEM read, sustained contention with forced debug
// slots, debug write/readback, back-to-back MEM accesses, dropped request,
// reset mid-access and the debug write-protection option.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
   logic clk;
   logic resetn;
   int   n_tests;
   int   n_fail;

   dm_arbiter_if bus ();

   dm_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   dm_arbiter_chk u_chk_mem (
      .clk_i(clk), .rst_n_i(resetn), .req_i(bus.mem_req), .gnt_i(bus.mem_gnt),
      .addr_i(bus.mem_addr), .wen_i(bus.mem_wen), .wdata_i(bus.mem_wdata)
   );

   dm_arbiter_chk u_chk_dbg (
      .clk_i(clk), .rst_n_i(resetn), .req_i(bus.dbg_req), .gnt_i(bus.dbg_gnt),
      .addr_i(bus.dbg_addr), .wen_i(bus.dbg_wen), .wdata_i(bus.dbg_wdata)
   );

   // Synchronous-read RAM model, read-old-data on simultaneous write.
   logic [31:0] ram [0:255];

   always @(posedge clk) begin
      bus.dm_rdata <= ram[bus.dm_addr[9:2]];
      for (int i = 0; i < 4; i++) begin
         if (bus.dm_wen[i]) begin
            ram[bus.dm_addr[9:2]][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
         end
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports();
      bus.mem_req   = 1'b0;
      bus.mem_addr  = 32'h0000_0000;
      bus.mem_wen   = 4'b0000;
      bus.mem_wdata = 32'h0000_0000;
      bus.dbg_req   = 1'b0;
      bus.dbg_addr  = 32'h0000_0000;
      bus.dbg_wen   = 4'b0000;
      bus.dbg_wdata = 32'h0000_0000;
   endtask

   initial begin
      logic [11:0] pat;
      logic [3:0]  cnt_exp;
      logic        is_d;

      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0000_0000;
      ram[4]  = 32'hDEAD_BEEF;   // byte address 0x10
      ram[16] = 32'hAABB_CC00;   // byte address 0x40
      bus.dm_rdata = 32'h0000_0000;
      idle_ports();
      resetn = 1'b0;

      // Reset state
      #2;
      check("rst_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
      check("rst_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
      check("rst_werr",       {31'd0, bus.dbg_werr},   32'd0);
      check("rst_dm_wen",     {28'd0, bus.dm_wen},     32'd0);
      check("rst_dm_addr",    bus.dm_addr,             32'd0);
      check("rst_dm_wdata",   bus.dm_wdata,            32'd0);
      check("rst_starve",     {28'd0, dut.starve_cnt_q}, 32'd0);
      step();
      step();
      resetn = 1'b1;
      step();

      // 1: single MEM read
      bus.mem_req  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      #1;
      check("t1_mem_gnt", {31'd0, bus.mem_gnt}, 32'd1);
      check("t1_dm_addr", bus.dm_addr, 32'h0000_0010);
      step();
      bus.mem_req = 1'b0;
      check("t1_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd1);
      check("t1_mem_rdata",  bus.mem_rdata, 32'hDEAD_BEEF);
      check("t1_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
      step();
      check("t1_rvalid_drop", {31'd0, bus.mem_rvalid}, 32'd0);

      // 2: sustained contention, expected MMMMDMMMMDMM (D at slots 4 and 9)
      pat     = 12'b0010_0001_0000;
      cnt_exp = 4'd0;
      bus.mem_req  = 1'b1;
      bus.mem_addr = 32'h0000_0040;
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 32'h0000_0044;
      for (int i = 0; i < 12; i++) begin
         is_d = pat[i];
         #1;
         check($sformatf("t2_dbg_gnt[%0d]", i), {31'd0, bus.dbg_gnt}, {31'd0, is_d});
         check($sformatf("t2_mem_gnt[%0d]", i), {31'd0, bus.mem_gnt}, {31'd0, !is_d});
         check($sformatf("t2_dm_addr[%0d]", i), bus.dm_addr,
               is_d ? 32'h0000_0044 : 32'h0000_0040);
         step();
         cnt_exp = is_d ? 4'd0 : ((cnt_exp == 4'd15) ? 4'd15 : cnt_exp + 4'd1);
         check($sformatf("t2_starve[%0d]", i), {28'd0, dut.starve_cnt_q}, {28'd0, cnt_exp});
         check($sformatf("t2_dbg_rvalid[%0d]", i), {31'd0, bus.dbg_rvalid}, {31'd0, is_d});
      end
      idle_ports();
      step();
      check("t2_starve_clear", {28'd0, dut.starve_cnt_q}, 32'd0);

      // 3: debug partial write then readback
      bus.dbg_req   = 1'b1;
      bus.dbg_addr  = 32'h0000_0020;
      bus.dbg_wen   = 4'b0011;
      bus.dbg_wdata = 32'h1234_ABCD;
      #1;
      check("t3_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
      check("t3_dm_wen",  {28'd0, bus.dm_wen}, 32'h3);
      check("t3_dm_wdata", bus.dm_wdata, 32'h1234_ABCD);
      step();
      bus.dbg_wen   = 4'b0000;
      bus.dbg_wdata = 32'h0000_0000;
      check("t3_wr_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
      check("t3_wr_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
      step();
      bus.dbg_req = 1'b0;
      check("t3_rd_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
      check("t3_rd_lower", {16'd0, bus.dbg_rdata[15:0]}, 32'h0000_ABCD);
      check("t3_rd_word",  bus.dbg_rdata, 32'h0000_ABCD);
      step();
      check("t3_rvalid_once", {31'd0, bus.dbg_rvalid}, 32'd0);

      // 4: back-to-back MEM write then read of the same word
      bus.mem_req   = 1'b1;
      bus.mem_addr  = 32'h0000_0040;
      bus.mem_wen   = 4'b0001;
      bus.mem_wdata = 32'h0000_0055;
      #1;
      check("t4_wr_dm_wen", {28'd0, bus.dm_wen}, 32'h1);
      step();
      bus.mem_wen   = 4'b0000;
      bus.mem_wdata = 32'h0000_0000;
      check("t4_rvalid_n1", {31'd0, bus.mem_rvalid}, 32'd1);
      #1;
      check("t4_rd_gnt", {31'd0, bus.mem_gnt}, 32'd1);
      step();
      bus.mem_req = 1'b0;
      check("t4_rvalid_n2", {31'd0, bus.mem_rvalid}, 32'd1);
      check("t4_rdata_n2", bus.mem_rdata, 32'hAABB_CC55);
      step();

      // Dropped request: debug loses, then withdraws; nothing reaches RAM
      bus.mem_req   = 1'b1;
      bus.mem_addr  = 32'h0000_0040;
      bus.dbg_req   = 1'b1;
      bus.dbg_addr  = 32'h0000_0080;
      bus.dbg_wen   = 4'b1111;
      bus.dbg_wdata = 32'h0BAD_0BAD;
      #1;
      check("drop_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
      step();
      idle_ports();
      check("drop_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
      step();
      check("drop_dbg_rvalid2", {31'd0, bus.dbg_rvalid}, 32'd0);
      check("drop_ram", ram[32], 32'h0000_0000);

      // 5: reset asserted during a MEM grant cycle
      bus.mem_req  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 32'h0000_0044;
      step();
      step();
      check("t5_starve_pre", {28'd0, dut.starve_cnt_q}, 32'd2);
      check("t5_mem_gnt", {31'd0, bus.mem_gnt}, 32'd1);
      #2;
      resetn = 1'b0;
      idle_ports();
      #1;
      check("t5_starve_rst", {28'd0, dut.starve_cnt_q}, 32'd0);
      check("t5_rvalid_rst", {31'd0, bus.mem_rvalid}, 32'd0);
      step();
      check("t5_rvalid_lost", {31'd0, bus.mem_rvalid}, 32'd0);
      resetn = 1'b1;
      step();
      check("t5_rvalid_after", {31'd0, bus.mem_rvalid}, 32'd0);
      bus.mem_req  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      #1;
      check("t5_fresh_gnt", {31'd0, bus.mem_gnt}, 32'd1);
      step();
      bus.mem_req = 1'b0;
      check("t5_fresh_rvalid", {31'd0, bus.mem_rvalid}, 32'd1);
      check("t5_fresh_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
      step();

      // 6: debug write outside the protected window, then inside
      bus.dbg_req   = 1'b1;
      bus.dbg_addr  = 32'h0000_2000;
      bus.dbg_wen   = 4'b1111;
      bus.dbg_wdata = 32'hCAFE_F00D;
      #1;
      check("t6_oob_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
`ifdef DM_ARB_DBG_WPROT_EN
      check("t6_oob_dm_wen", {28'd0, bus.dm_wen}, 32'h0);
`else
      check("t6_oob_dm_wen", {28'd0, bus.dm_wen}, 32'hF);
`endif
      check("t6_werr_pre", {31'd0, bus.dbg_werr}, 32'd0);
      step();
      bus.dbg_addr  = 32'h0000_0100;
      bus.dbg_wdata = 32'h1122_3344;
      check("t6_oob_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
`ifdef DM_ARB_DBG_WPROT_EN
      check("t6_werr_set", {31'd0, bus.dbg_werr}, 32'd1);
      check("t6_oob_ram", ram[0], 32'h0000_0000);
`else
      check("t6_werr_set", {31'd0, bus.dbg_werr}, 32'd0);
      check("t6_oob_ram", ram[0], 32'hCAFE_F00D);
`endif
      #1;
      check("t6_in_dm_wen", {28'd0, bus.dm_wen}, 32'hF);
      step();
      idle_ports();
      check("t6_in_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
      check("t6_in_ram", ram[64], 32'h1122_3344);
      step();
`ifdef DM_ARB_DBG_WPROT_EN
      check("t6_werr_sticky", {31'd0, bus.dbg_werr}, 32'd1);
`else
      check("t6_werr_sticky", {31'd0, bus.dbg_werr}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
